// File: rtl/llrb_retry_buffer_pkg.sv
// Shared types and helpers for the link-layer retry buffer (llrb_retry_buffer).
// Holds the flit width, the flit type, the replay FSM state enum and the
// modular pointer-advance helper used by every ring pointer.
package llr_pkg;

  // Flit plus CRC width as produced by the CRC generator.
  localparam int FLIT_W = 528;

  typedef logic [FLIT_W-1:0] flit_t;

  // Replay FSM states. The top maps these onto plain localparam codes.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REPLAY = 2'd1,
    DONE   = 2'd2
  } llrb_state_t;

  // Advance a ring pointer by n modulo the effective depth ed.
  // Callers guarantee ptr < ed and n <= ed, so one conditional subtract
  // is enough to fold the sum back into range.
  function automatic logic [8:0] ptr_inc(input logic [8:0] ptr,
                                         input logic [8:0] n,
                                         input logic [8:0] ed);
    logic [9:0] sum;
    sum = {1'b0, ptr} + {1'b0, n};
    if (sum >= {1'b0, ed}) sum = sum - {1'b0, ed};
    return sum[8:0];
  endfunction

endpackage

// File: rtl/llrb_retry_buffer_if.sv
// Data-path bundle of the retry buffer: flit capture from the CRC
// generator, Full_Ack count, replay control and the replayed flit to MUX-2.
//
// Handshake: every i_* strobe (i_wr_en, i_ack_valid, i_replay_start,
// i_rd_en) is a single-cycle request sampled on the rising clock edge; the
// buffer has no back-pressure. A replay read requested by i_rd_en in cycle t
// is answered by o_llrb_flit with o_llrb_flit_valid high during cycle t+1
// only; o_llrb_flit is meaningful only while o_llrb_flit_valid is high.
interface llrb_retry_buffer_if import llr_pkg::*; ();

  logic       i_wr_en;
  flit_t      i_flit_w_crc;
  logic       i_ack_valid;
  logic [7:0] i_ack_num;
  logic       i_replay_start;
  logic       i_rd_en;
  flit_t      o_llrb_flit;
  logic       o_llrb_flit_valid;

  // Retry controller / CRC side that drives requests.
  modport master (
    output i_wr_en, i_flit_w_crc, i_ack_valid, i_ack_num,
           i_replay_start, i_rd_en,
    input  o_llrb_flit, o_llrb_flit_valid
  );

  // Retry buffer side.
  modport slave (
    input  i_wr_en, i_flit_w_crc, i_ack_valid, i_ack_num,
           i_replay_start, i_rd_en,
    output o_llrb_flit, o_llrb_flit_valid
  );

endinterface

// File: rtl/llrb_retry_buffer_mem.sv
// llrb_mem: simple dual-port synchronous RAM for the retry ring.
// One write port, one read port, registered read data. The array itself is
// never reset; only the read-data register clears so the replayed flit
// output starts at zero.
module llrb_mem import llr_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int W     = FLIT_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rd_data;

  // Write port: capture one entry per accepted flit.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Read port: registered data, held between reads, cleared on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/llrb_retry_buffer.sv
// llrb_retry_buffer: link-layer retry ring downstream of the CRC generator.
// Captures every transmitted flit, frees entries on Full_Ack counts, and on
// a retry request replays all unacknowledged flits oldest-first to MUX-2.
// Optional build macro: LLRB_PARITY_EN adds an even-parity bit per entry and
// flags o_parity_err on replay reads whose stored parity does not match.
module llrb_retry_buffer import llr_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [7:0]                i_llr_wrap_value,
  llrb_retry_buffer_if.slave        io_bus,
  output logic [7:0]                o_wrt_ptr,
  output logic [7:0]                o_eseq,
  output logic [8:0]                o_num_free_buff,
  output logic [8:0]                o_buffer_consumed,
  output logic                      o_full,
  output logic                      o_wr_overflow,
  output logic                      o_replay_active,
  output logic                      o_replay_done,
  output logic                      o_parity_err,
  output logic [1:0]                o_dbg_state
);

  // Replay FSM codes, mirroring llrb_state_t.
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_REPLAY = REPLAY;
  localparam logic [1:0] S_DONE   = DONE;

`ifdef LLRB_PARITY_EN
  localparam int MEM_W = FLIT_W + 1;
`else
  localparam int MEM_W = FLIT_W;
`endif

  // Ring state.
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_free_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [8:0]       r_count;
  logic [8:0]       r_remaining;
  logic [8:0]       r_ed;
  logic [1:0]       r_state;
  logic             r_valid;
  logic             r_wr_overflow;

  // Combinational helpers.
  logic [8:0]       w_ed_in;
  logic             w_full;
  logic             w_wr_acc;
  logic [8:0]       w_ack_n;
  logic [8:0]       w_count_next;
  logic             w_idle;
  logic             w_rd_fire;
  logic [MEM_W-1:0] w_mem_wdata;
  logic [MEM_W-1:0] w_mem_rdata;

  // Effective depth requested by the register file, clamped to the RAM.
  assign w_ed_in = ({1'b0, i_llr_wrap_value} >= 9'(DEPTH - 1))
                   ? 9'(DEPTH)
                   : {1'b0, i_llr_wrap_value} + 9'd1;

  // Full is judged on the count before this cycle's write/ack update.
  assign w_full   = (r_count == r_ed);
  assign w_wr_acc = io_bus.i_wr_en && !w_full;

  // Acks never release more entries than are outstanding.
  always_comb begin
    w_ack_n = 9'd0;
    if (io_bus.i_ack_valid) begin
      if ({1'b0, io_bus.i_ack_num} < r_count) w_ack_n = {1'b0, io_bus.i_ack_num};
      else                                    w_ack_n = r_count;
    end
  end

  assign w_count_next = r_count + {8'd0, w_wr_acc} - w_ack_n;
  assign w_idle       = (r_state == S_IDLE);
  // A replay read happens only in REPLAY with entries still owed.
  assign w_rd_fire    = (r_state == S_REPLAY) && io_bus.i_rd_en && (r_remaining != 9'd0);

  // Depth is only re-latched while the ring is idle and empty, so the
  // modulus never changes under live entries.
  always_ff @(posedge i_clk) begin
    if (i_rst || (w_idle && (r_count == 9'd0))) r_ed <= w_ed_in;
  end

  // Write pointer, free pointer, occupancy and overflow pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr      <= '0;
      r_free_ptr    <= '0;
      r_count       <= 9'd0;
      r_wr_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= PTR_W'(ptr_inc(9'(r_wr_ptr), 9'd1, r_ed));
      r_free_ptr    <= PTR_W'(ptr_inc(9'(r_free_ptr), w_ack_n, r_ed));
      r_count       <= w_count_next;
      r_wr_overflow <= io_bus.i_wr_en && w_full;
    end
  end

  // Replay FSM: snapshot the unacked window, stream it out, pulse done.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_rd_ptr    <= '0;
      r_remaining <= 9'd0;
      r_valid     <= 1'b0;
    end else begin
      r_valid <= w_rd_fire;
      case (r_state)
        S_IDLE: begin
          if (io_bus.i_replay_start) begin
            // Snapshot: later writes are not part of this replay.
            r_rd_ptr    <= r_free_ptr;
            r_remaining <= r_count;
            r_state     <= (r_count == 9'd0) ? S_DONE : S_REPLAY;
          end
        end
        S_REPLAY: begin
          if (w_rd_fire) begin
            r_rd_ptr    <= PTR_W'(ptr_inc(9'(r_rd_ptr), 9'd1, r_ed));
            r_remaining <= r_remaining - 9'd1;
          end
          // Exit once the final read has been issued.
          if (r_remaining == 9'd0) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LLRB_PARITY_EN
  // Entry = {even parity, flit}; an intact entry XORs to zero.
  assign w_mem_wdata  = {^io_bus.i_flit_w_crc, io_bus.i_flit_w_crc};
  assign o_parity_err = r_valid && (^w_mem_rdata);
`else
  assign w_mem_wdata  = io_bus.i_flit_w_crc;
  assign o_parity_err = 1'b0;
`endif

  llrb_mem #(
    .DEPTH (DEPTH),
    .W     (MEM_W),
    .AW    (PTR_W)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_mem_wdata),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_mem_rdata)
  );

  assign io_bus.o_llrb_flit       = w_mem_rdata[FLIT_W-1:0];
  assign io_bus.o_llrb_flit_valid = r_valid;

  assign o_wrt_ptr         = 8'(r_wr_ptr);
  assign o_eseq            = 8'(r_free_ptr);
  assign o_buffer_consumed = r_count;
  assign o_num_free_buff   = r_ed - r_count;
  assign o_full            = w_full;
  assign o_wr_overflow     = r_wr_overflow;
  assign o_replay_active   = (r_state == S_REPLAY);
  assign o_replay_done     = (r_state == S_DONE);
  assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_llrb_retry_buffer.sv
// Testbench for llrb_retry_buffer: directed plan items plus a randomized
// write/ack/replay phase, checked against a queue-based reference model.
module tb_llrb_retry_buffer import llr_pkg::*; ();

  localparam int DEPTH = 256;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wrap = 8'd7;
  always #5 clk = ~clk;

  llrb_retry_buffer_if bus ();

  logic [7:0] o_wrt_ptr, o_eseq;
  logic [8:0] o_num_free_buff, o_buffer_consumed;
  logic       o_full, o_wr_overflow, o_replay_active, o_replay_done, o_parity_err;
  logic [1:0] o_dbg_state;

  llrb_retry_buffer #(.DEPTH(DEPTH)) u_dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_llr_wrap_value  (wrap),
    .io_bus            (bus),
    .o_wrt_ptr         (o_wrt_ptr),
    .o_eseq            (o_eseq),
    .o_num_free_buff   (o_num_free_buff),
    .o_buffer_consumed (o_buffer_consumed),
    .o_full            (o_full),
    .o_wr_overflow     (o_wr_overflow),
    .o_replay_active   (o_replay_active),
    .o_replay_done     (o_replay_done),
    .o_parity_err      (o_parity_err),
    .o_dbg_state       (o_dbg_state)
  );

  // ---------------- reference model ----------------
  typedef struct {
    flit_t f;
    bit    bad;
  } ent_t;

  ent_t              m_q[$];        // unacked flits, oldest first
  int                m_wp, m_es, m_ed;
  bit                m_ovf;
  logic [FLIT_W-1:0] exp_q[$];      // flits expected on the replay port
  bit                exp_perr_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [FLIT_W-1:0] act,
                     input logic [FLIT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int ed_of(input int w);
    return (w >= DEPTH - 1) ? DEPTH : w + 1;
  endfunction

  function automatic flit_t rnd_flit();
    flit_t f = '0;
    for (int i = 0; i < 17; i++) f = {f[FLIT_W-33:0], 32'($urandom)};
    return f;
  endfunction

  // Apply this cycle's inputs to the model (uses pre-edge model state).
  task automatic model_step();
    int pre, n;
    pre   = m_q.size();
    m_ovf = 0;
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      exp_perr_q.delete();
      m_wp = 0; m_es = 0; m_ed = ed_of(int'(wrap));
      return;
    end
    if (bus.i_replay_start) begin
      foreach (m_q[i]) begin
        exp_q.push_back(m_q[i].f);
        exp_perr_q.push_back(m_q[i].bad);
      end
    end
    if (bus.i_wr_en) begin
      if (pre == m_ed) m_ovf = 1;
      else begin
        m_q.push_back('{f: bus.i_flit_w_crc, bad: 1'b0});
        m_wp = (m_wp + 1) % m_ed;
      end
    end
    if (bus.i_ack_valid) begin
      n = (int'(bus.i_ack_num) < pre) ? int'(bus.i_ack_num) : pre;
      repeat (n) void'(m_q.pop_front());
      m_es = (m_es + n) % m_ed;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    bus.i_wr_en = 0; bus.i_ack_valid = 0; bus.i_ack_num = 0;
    bus.i_replay_start = 0; bus.i_rd_en = 0; rst = 0;
  endtask

  task automatic do_reset(input logic [7:0] w);
    wrap = w; rst = 1; tick();
    rst = 1; tick();
  endtask

  task automatic wr(input int k);
    repeat (k) begin
      bus.i_wr_en = 1; bus.i_flit_w_crc = rnd_flit(); tick(); check_status();
    end
  endtask

  task automatic ack(input int n);
    bus.i_ack_valid = 1; bus.i_ack_num = 8'(n); tick(); check_status();
  endtask

  task automatic check_status();
    chk("wrt_ptr",  o_wrt_ptr, m_wp);
    chk("eseq",     o_eseq, m_es);
    chk("consumed", o_buffer_consumed, m_q.size());
    chk("num_free", o_num_free_buff, m_ed - m_q.size());
    chk("full",     o_full, m_q.size() == m_ed);
    chk("overflow", o_wr_overflow, m_ovf);
  endtask

  // Start a replay and keep reading until the done pulse (bounded).
  task automatic do_replay(input bit hold, input bit traffic,
                           output int done_it, output int first_v, output int last_v);
    bit seen;
    bus.i_replay_start = 1; tick(); check_status();
    done_it = -1; first_v = -1; last_v = -1;
    seen = o_replay_done;
    for (int it = 0; it < 400 && !seen; it++) begin
      bus.i_rd_en = hold ? 1'b1 : 1'($urandom_range(0, 1));
      if (traffic) begin
        bus.i_wr_en = 1'($urandom_range(0, 2) == 0);
        bus.i_flit_w_crc = rnd_flit();
        bus.i_ack_valid = 1'($urandom_range(0, 3) == 0);
        bus.i_ack_num = 8'($urandom_range(0, 3));
      end
      tick(); check_status();
      if (o_llrb_flit_valid_s()) begin
        if (first_v < 0) first_v = it;
        last_v = it;
      end
      if (o_replay_done) begin
        done_it = it; seen = 1;
      end else chk("replay_active", o_replay_active, 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL replay_timeout: got no done expected done within 400 cycles");
    end
    chk("replay_drained", exp_q.size(), 0);
    tick();
    chk("idle_after_done", o_dbg_state, 2'd0);
  endtask

  function automatic bit o_llrb_flit_valid_s();
    return bus.o_llrb_flit_valid;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (bus.o_llrb_flit_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL replay_flit: got unexpected valid flit expected none");
      end else begin
        chk("replay_flit", bus.o_llrb_flit, exp_q.pop_front());
        chk("parity_err", o_parity_err, exp_perr_q.pop_front());
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    int d, f, l;
    bus.i_wr_en = 0; bus.i_flit_w_crc = '0; bus.i_ack_valid = 0;
    bus.i_ack_num = 0; bus.i_replay_start = 0; bus.i_rd_en = 0;

    // Reset state, ED = 8.
    do_reset(8'd7);
    check_status();
    chk("rst_free", o_num_free_buff, 9'd8);
    chk("rst_valid", bus.o_llrb_flit_valid, 1'b0);
    chk("rst_flit", bus.o_llrb_flit, '0);
    chk("rst_done", o_replay_done, 1'b0);
    chk("rst_active", o_replay_active, 1'b0);
    chk("rst_perr", o_parity_err, 1'b0);
    chk("rst_state", o_dbg_state, 2'd0);

    // Fill to ED, then overflow.
    wr(8);
    chk("fill_full", o_full, 1'b1);
    chk("fill_free", o_num_free_buff, 9'd0);
    wr(1);
    chk("ovf_pulse", o_wr_overflow, 1'b1);
    chk("ovf_wrt_ptr", o_wrt_ptr, 8'd0);
    tick(); check_status();
    chk("ovf_one_cycle", o_wr_overflow, 1'b0);

    // Ack wrap.
    do_reset(8'd7);
    wr(6); ack(4); wr(5);
    chk("wrap_eseq", o_eseq, 8'd4);
    chk("wrap_wrt_ptr", o_wrt_ptr, 8'd3);
    chk("wrap_consumed", o_buffer_consumed, 9'd7);

    // Directed replay of entries 5,6,7 with i_rd_en held.
    do_reset(8'd7);
    wr(8); ack(5);
    chk("replay_eseq", o_eseq, 8'd5);
    do_replay(1'b1, 1'b0, d, f, l);
    chk("replay_first_lat", f, 0);
    chk("replay_last", l, 2);
    checks++;
    if (!(d > l && d <= l + 2)) begin
      errors++;
      $display("FAIL replay_done_timing: got %0d expected %0d..%0d", d, l + 1, l + 2);
    end

    // Simultaneous write + ack, oversized ack.
    do_reset(8'd7);
    wr(4);
    bus.i_wr_en = 1; bus.i_flit_w_crc = rnd_flit();
    bus.i_ack_valid = 1; bus.i_ack_num = 8'd2; tick(); check_status();
    chk("simul_count", o_buffer_consumed, 9'd3);
    ack(10);
    chk("bigack_count", o_buffer_consumed, 9'd0);
    chk("bigack_eseq", o_eseq, 8'd5);
    chk("bigack_eq_wp", o_eseq, o_wrt_ptr);

    // Empty replay.
    bus.i_replay_start = 1; tick();
    chk("empty_done", o_replay_done, 1'b1);
    chk("empty_valid", bus.o_llrb_flit_valid, 1'b0);
    tick();
    chk("empty_done_pulse", o_replay_done, 1'b0);
    chk("empty_idle", o_dbg_state, 2'd0);

    // Reset in the middle of a replay.
    do_reset(8'd7);
    wr(5); ack(2);
    bus.i_replay_start = 1; tick();
    bus.i_rd_en = 1; tick();
    bus.i_rd_en = 1; rst = 1; tick();
    chk("midrst_valid", bus.o_llrb_flit_valid, 1'b0);
    chk("midrst_state", o_dbg_state, 2'd0);
    chk("midrst_active", o_replay_active, 1'b0);
    chk("midrst_wp", o_wrt_ptr, 8'd0);
    chk("midrst_eseq", o_eseq, 8'd0);
    chk("midrst_count", o_buffer_consumed, 9'd0);

`ifdef LLRB_PARITY_EN
    // Corrupt the stored parity bit of entry 2, then replay it.
    do_reset(8'd7);
    wr(4);
    u_dut.u_mem.r_mem[2][FLIT_W] = ~u_dut.u_mem.r_mem[2][FLIT_W];
    m_q[2].bad = 1'b1;
    do_replay(1'b1, 1'b0, d, f, l);
`endif

    // Randomized traffic, ED = 13, with replays interleaved.
    do_reset(8'd12);
    for (int r = 0; r < 30; r++) begin
      for (int c = 0; c < 15; c++) begin
        bus.i_wr_en = 1'($urandom_range(0, 9) < 7);
        bus.i_flit_w_crc = rnd_flit();
        bus.i_ack_valid = 1'($urandom_range(0, 9) < 3);
        bus.i_ack_num = ($urandom_range(0, 7) == 0) ? 8'd20 : 8'($urandom_range(0, 5));
        tick(); check_status();
      end
      if ($urandom_range(0, 1) == 1)
        do_replay(1'($urandom_range(0, 1)), 1'b1, d, f, l);
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
